// File: rtl/seq_divider_param.sv
// Restoring shift-subtract divider: unsigned 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_mode port and the FIX sign-correction state.
module seq_divider_param #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic           signed_mode,
`endif
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz,
  output logic           ovf
);

  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [1:0] FIX  = 2'd3;
  localparam logic [N-1:0] QMIN_MAG = {1'b1, {(N-1){1'b0}}};
`endif

  logic [1:0]     state;
  logic [2*N:0]   acc;
  logic [2*N:0]   acc_next;
  logic [N-1:0]   div_r;
  logic [CW-1:0]  cnt;
  logic [N:0]     window;
  logic [N:0]     diff;
  logic           take;
  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic           dvd_neg;
  logic           dvs_neg;
  logic           sm_r;
  logic           qneg_r;
  logic           rneg_r;
  logic [N-1:0]   qmag;
  logic [N-1:0]   rmag;
  logic           fix_ovf;
`endif

  // Operand magnitudes; in signed mode the divide runs on absolute values.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_neg = signed_mode & dividend[2*N-1];
    dvs_neg = signed_mode & divisor[N-1];
    if (dvd_neg) dvd_mag = -dividend;
    if (dvs_neg) dvs_mag = -divisor;
    qmag    = acc[N-1:0];
    rmag    = acc[2*N-1:N];
    fix_ovf = qneg_r ? (qmag > QMIN_MAG) : qmag[N-1];
`endif
  end

  // One restoring step: shift left, then subtract if the (N+1)-bit window covers the divisor.
  always_comb begin
    window   = acc[2*N-1:N-1];
    take     = acc[2*N] || (window >= {1'b0, div_r});
    diff     = window - {1'b0, div_r};
    acc_next = {window, acc[N-2:0], 1'b0};
    if (take) acc_next = {diff, acc[N-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      div_r     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sm_r      <= 1'b0;
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            div_r <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sm_r   <= signed_mode;
            qneg_r <= dvd_neg ^ dvs_neg;
            rneg_r <= dvd_neg;
`endif
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[N-1:0];
            end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
              state     <= DONE;
              done      <= 1'b1;
              ovf       <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              acc   <= {1'b0, dvd_mag};
              cnt   <= CW'(N);
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (sm_r) begin
              state <= FIX;
            end else begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= acc_next[N-1:0];
              remainder <= acc_next[2*N-1:N];
            end
`else
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= acc_next[N-1:0];
            remainder <= acc_next[2*N-1:N];
`endif
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Apply signs to the magnitude result; truncating division keeps the dividend's sign on the remainder.
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (fix_ovf) begin
            ovf       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            quotient  <= qneg_r ? -qmag : qmag;
            remainder <= rneg_r ? -rmag : rmag;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed self-checking bench for seq_divider_param (N=4 and N=8 instances).
// Signed-mode vectors run only when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic [7:0]  dvd4 = '0;
  logic [3:0]  dvs4 = '0;
  logic        sm4 = 1'b0;
  logic        busy4, done4, dbz4, ovf4;
  logic [3:0]  q4, r4;

  logic        start8 = 1'b0;
  logic [15:0] dvd8 = '0;
  logic [7:0]  dvs8 = '0;
  logic        busy8, done8, dbz8, ovf8;
  logic [7:0]  q8, r8;

  int nassert = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  seq_divider_param #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_mode(sm4),
`endif
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .dbz(dbz4), .ovf(ovf4)
  );

  seq_divider_param #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .dbz(dbz8), .ovf(ovf8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns at the sample point of the first cycle after the accepting edge.
  task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs, input logic sm);
    dvd4   = dvd;
    dvs4   = dvs;
    sm4    = sm;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [7:0] dvd, input logic [3:0] dvs, input logic sm,
                       input int lat, input logic [3:0] eq, input logic [3:0] er,
                       input logic edbz, input logic eovf);
    applyStimulus(dvd, dvs, sm);
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) @(negedge clk);
      if (i < lat) begin
        checkOutput({tag, "_early_done"}, 32'(done4), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy4), 32'd1);
      end else begin
        checkOutput({tag, "_done"}, 32'(done4), 32'd1);
        checkOutput({tag, "_busy_low"}, 32'(busy4), 32'd0);
        checkOutput({tag, "_q"}, 32'(q4), 32'(eq));
        checkOutput({tag, "_r"}, 32'(r4), 32'(er));
        checkOutput({tag, "_dbz"}, 32'(dbz4), 32'(edbz));
        checkOutput({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
      end
    end
  endtask

  // N=8 op with expectations taken from the bench's own integer division.
  task automatic runOp8(input string tag, input logic [15:0] dvd, input logic [7:0] dvs);
    int eq, er;
    eq = int'(dvd) / int'(dvs);
    er = int'(dvd) % int'(dvs);
    dvd8   = dvd;
    dvs8   = dvs;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput({tag, "_early_done"}, 32'(done8), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done8), 32'd1);
    checkOutput({tag, "_q"}, 32'(q8), 32'(eq));
    checkOutput({tag, "_r"}, 32'(r8), 32'(er));
  endtask

  initial begin
    logic [7:0] hi;
    logic [7:0] d;

    #1;
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_done", 32'(done4), 32'd0);
    checkOutput("rst_q", 32'(q4), 32'd0);
    checkOutput("rst_r", 32'(r4), 32'd0);
    checkOutput("rst_dbz", 32'(dbz4), 32'd0);
    checkOutput("rst_ovf", 32'(ovf4), 32'd0);
    checkOutput("rst_done8", 32'(done8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runOp("div135_13", 8'd135, 4'd13, 1'b0, 5, 4'd10, 4'd5, 1'b0, 1'b0);
    runOp("b2b_6_4", 8'd6, 4'd4, 1'b0, 5, 4'd1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(done4), 32'd0);
    checkOutput("hold_q", 32'(q4), 32'd1);
    checkOutput("hold_r", 32'(r4), 32'd2);

    runOp("dbz_77_0", 8'd77, 4'd0, 1'b0, 1, 4'hF, 4'd13, 1'b1, 1'b0);
    runOp("ovf_200_3", 8'd200, 4'd3, 1'b0, 1, 4'd0, 4'd0, 1'b0, 1'b1);
    runOp("qmax_239_15", 8'd239, 4'd15, 1'b0, 5, 4'd15, 4'd14, 1'b0, 1'b0);
    runOp("qzero_14_15", 8'd14, 4'd15, 1'b0, 5, 4'd0, 4'd14, 1'b0, 1'b0);
    runOp("ovf_255_15", 8'd255, 4'd15, 1'b0, 1, 4'd0, 4'd0, 1'b0, 1'b1);

    // A start pulse while busy must not disturb the running operation.
    applyStimulus(8'd135, 4'd13, 1'b0);
    @(negedge clk);
    dvd4 = 8'd6;
    dvs4 = 4'd4;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("ignore_busy", 32'(busy4), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("ignore_done", 32'(done4), 32'd1);
    checkOutput("ignore_q", 32'(q4), 32'd10);
    checkOutput("ignore_r", 32'(r4), 32'd5);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(8'd135, 4'd13, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy4), 32'd0);
    checkOutput("midrst_done", 32'(done4), 32'd0);
    checkOutput("midrst_q", 32'(q4), 32'd0);
    checkOutput("midrst_r", 32'(r4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 32'(done4), 32'd0);
    end
    checkOutput("midrst_idle", 32'(busy4), 32'd0);

    runOp8("n8_50000_200", 16'd50000, 8'd200);
    for (int k = 0; k < 1000; k++) begin
      d  = 8'($urandom_range(1, 255));
      hi = 8'($urandom % d);
      runOp8("n8_sweep", {hi, 8'($urandom)}, d);
    end
    @(negedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
    runOp("s_m7_2", 8'hF9, 4'd2, 1'b1, 6, 4'hD, 4'hF, 1'b0, 1'b0);
    runOp("s_m64_m1", 8'hC0, 4'hF, 1'b1, 1, 4'd0, 4'd0, 1'b0, 1'b1);
    runOp("s_64_8_fixovf", 8'd64, 4'd8, 1'b1, 6, 4'd0, 4'd0, 1'b0, 1'b1);
    runOp("s_m64_8_qmin", 8'hC0, 4'd8, 1'b1, 6, 4'h8, 4'd0, 1'b0, 1'b0);
    runOp("s_unsigned_mode", 8'd135, 4'd13, 1'b0, 5, 4'd10, 4'd5, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised restoring shift-subtract divider, unsigned 2N-bit dividend by N-bit divisor, producing N-bit quotient and N-bit remainder.
- Computes one quotient bit per clock; start/busy/done handshake; divide-by-zero and overflow detection.
- Generalises the fixed 8/4 divider for datapath arithmetic users of any width; optional signed mode.

Parameters:
- N, 4, divisor/quotient/remainder width; dividend is 2N bits; legal N >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  2N  dividend, captured on accepted start.
- divisor  input  N  divisor, captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse: results valid.
- quotient  output  N  result quotient, held until next accepted start.
- remainder  output  N  result remainder, held until next accepted start.
- dbz  output  1  divide-by-zero flag for last operation.
- ovf  output  1  quotient overflow flag for last operation.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, dbz, ovf = 0; quotient, remainder = 0; internal accumulator (2N+1 bits) and counter = 0. Reset mid-operation aborts it, and no done is issued.
- States: IDLE, CALC, DONE.
- IDLE/DONE: start=1 at an edge is accepted. Flags clear, operands are captured, and the next state is chosen:
  - divisor==0 -> DONE; dbz=1, quotient=all ones, remainder=dividend[N-1:0].
  - else dividend[2N-1:N] >= divisor -> DONE; ovf=1, quotient=0, remainder=0.
  - else -> CALC; acc={1'b0,dividend}, counter=N, busy=1.
- DONE lasts exactly one cycle with done=1, then returns to IDLE unless a new start is accepted in that cycle. Back-to-back operations are legal.
- CALC, each edge:
  - acc shifts left 1.
  - If acc[2N:N] >= divisor after the shift, subtract divisor from acc[2N:N] and set acc[0]=1.
  - Counter decrements; when it reaches 0, go to DONE.
  - In the DONE cycle: quotient=acc[N-1:0], remainder=acc[2N-1:N], busy=0.
- Latency: normal op has done high N+1 cycles after the accepting edge (N=4 -> 5 cycles). The error path has done high 1 cycle after it.
- start while busy=1 is ignored; operands are not re-sampled.
- Operand inputs may change freely after acceptance.
- Outputs are registered and never glitch. quotient/remainder/dbz/ovf are stable from the done pulse until the next accepted start.
- Arithmetic: compare/subtract on N+1 bits; no truncation. The invariant quotient*divisor+remainder == dividend and remainder < divisor must hold for all non-error cases.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit, sampled with start).
  - When signed_mode=1, operands are two's complement. Magnitudes are divided, then a state FIX (one extra cycle before DONE) applies signs:
    - quotient sign = dividend sign XOR divisor sign.
    - remainder sign = dividend sign (truncating division).
  - ovf is also set if the signed quotient is outside [-2^(N-1), 2^(N-1)-1]; in that case quotient=0 and remainder=0.
  - Signed latency is N+2 cycles.
  - signed_mode=0 behaves exactly as unsigned.
- Undefined: no signed_mode port, no FIX state, unsigned only.

Test Plan:
- N=4, dividend=135, divisor=13, start 1 cycle -> done 5 cycles later; quotient=10, remainder=5, dbz=0, ovf=0; busy high for 4 cycles.
- N=4, 6/4, issued in the DONE cycle of the previous op -> accepted back-to-back; quotient=1, remainder=2.
- N=4, divisor=0, dividend=77 -> done next cycle; dbz=1, quotient=4'hF, remainder=13. Then 200/3 -> done next cycle; ovf=1, quotient=0, remainder=0.
- N=4, 135/13 started, start re-pulsed with 6/4 at cycle 2 -> ignored; result 10 r 5. Then rst pulsed at cycle 2 of a new op -> all outputs 0 immediately, no done, IDLE.
- N=8: 50000/200 -> quotient=250, remainder=0, done after 9 cycles. Also a 1000-case random sweep checking the invariant.
- SEQ_DIVIDER_SIGNED_EN, N=4, signed_mode=1, -7/2 -> quotient=-3 (4'hD), remainder=-1 (4'hF), done after 6 cycles. Then -64/-1 -> ovf=1.
